// File: rtl/bfly_pkg.sv
// Shared widths, sample types and rounding helpers for the butterfly datapath.
package bfly_pkg;

    localparam int unsigned SIG             = 1;
    localparam int unsigned INT             = 3;
    localparam int unsigned FLT             = 6;
    localparam int unsigned WIDTH           = SIG + INT + FLT;
    localparam int unsigned LANES           = 16;
    localparam int unsigned FRAME_BEATS_DEF = 4;

    typedef logic [WIDTH:0]   wide_t;
    typedef logic [WIDTH-1:0] samp_t;

    typedef struct packed {
        samp_t re;
        samp_t im;
    } cplx_t;

    // (x + 1) >>> 1: with x = 2q + b this is q + b, which wraps naturally in WIDTH bits
    function automatic samp_t round_half(input wide_t x);
        return x[WIDTH:1] + samp_t'(x[0]);
    endfunction

    // The single input whose halved value exceeds the WIDTH-bit range
    function automatic logic round_ovf(input wide_t x);
        return x == {1'b0, {WIDTH{1'b1}}};
    endfunction

endpackage

// File: rtl/bfly_shuffle_buf_if.sv
// Input and output streaming bundle of the inter-stage shuffle buffer.
interface bfly_shuffle_buf_if;
    import bfly_pkg::*;

    logic  in_valid;
    logic  in_ready;
    wide_t in1_re [LANES];
    wide_t in1_im [LANES];
    wide_t in2_re [LANES];
    wide_t in2_im [LANES];

    logic  out_valid;
    logic  out_ready;
    samp_t out1_re [LANES];
    samp_t out1_im [LANES];
    samp_t out2_re [LANES];
    samp_t out2_im [LANES];

    modport slave (
        input  in_valid, in1_re, in1_im, in2_re, in2_im, out_ready,
        output in_ready, out_valid, out1_re, out1_im, out2_re, out2_im
    );

    modport master (
        output in_valid, in1_re, in1_im, in2_re, in2_im, out_ready,
        input  in_ready, out_valid, out1_re, out1_im, out2_re, out2_im
    );

endinterface

// File: rtl/bfly_round_sat.sv
// One-component halving round from WIDTH+1 to WIDTH bits.
// BFLY_SAT_EN: clamp the single overflowing value to the positive maximum; otherwise wrap.
module bfly_round_sat
    import bfly_pkg::*;
(
    input  wide_t x,
    output samp_t r
);

`ifdef BFLY_SAT_EN
    localparam samp_t SAMP_MAX = {1'b0, {(WIDTH-1){1'b1}}};

    // Clamp only the overflow case
    assign r = round_ovf(x) ? SAMP_MAX : round_half(x);
`else
    // Overflow wraps to the negative minimum
    assign r = round_half(x);
`endif

endmodule

// File: rtl/bfly_shuffle_buf.sv
// Ping-pong frame buffer between butterfly stages: rounds incoming sum/difference
// beats, stores one frame per bank and replays it stride-shuffled as din1/din2 pairs.
// Optional feature macro: BFLY_SAT_EN (saturating instead of wrapping round).
module bfly_shuffle_buf
    import bfly_pkg::*;
#(
    parameter int unsigned FRAME_BEATS = FRAME_BEATS_DEF
)(
    input  logic               clk,
    input  logic               rstn,
    bfly_shuffle_buf_if.slave  bus
);

    localparam int unsigned BEAT_W = $clog2(FRAME_BEATS);
    localparam int unsigned ROW_W  = BEAT_W + 1;
    localparam int unsigned ROWS   = 2 * FRAME_BEATS;

    typedef logic [BEAT_W-1:0] beat_t;
    typedef logic [ROW_W-1:0]  row_t;

    cplx_t mem [2][ROWS][LANES];
    logic  [1:0] full;
    logic  wr_sel;
    logic  rd_sel;
    beat_t wr_beat;
    beat_t rd_beat;

    samp_t r1_re [LANES];
    samp_t r1_im [LANES];
    samp_t r2_re [LANES];
    samp_t r2_im [LANES];

    logic  in_ready_c;
    logic  out_valid_c;
    logic  wr_en;
    logic  rd_en;
    logic  wr_last;
    logic  rd_last;
    row_t  wr_row1;
    row_t  wr_row2;
    row_t  rd_row1;
    row_t  rd_row2;

    // Per-component rounding of the incoming vectors
    for (genvar l = 0; l < LANES; l++) begin : g_round
        bfly_round_sat u_r1re (.x(bus.in1_re[l]), .r(r1_re[l]));
        bfly_round_sat u_r1im (.x(bus.in1_im[l]), .r(r1_im[l]));
        bfly_round_sat u_r2re (.x(bus.in2_re[l]), .r(r2_re[l]));
        bfly_round_sat u_r2im (.x(bus.in2_im[l]), .r(r2_im[l]));
    end

    assign in_ready_c  = !full[wr_sel];
    assign out_valid_c = full[rd_sel];
    assign wr_en       = bus.in_valid && in_ready_c;
    assign rd_en       = out_valid_c && bus.out_ready;
    assign wr_last     = (wr_beat == beat_t'(FRAME_BEATS - 1));
    assign rd_last     = (rd_beat == beat_t'(FRAME_BEATS - 1));

    // Beat b fills row b with the sums and row b+FRAME_BEATS with the differences
    assign wr_row1 = {1'b0, wr_beat};
    assign wr_row2 = {1'b1, wr_beat};

    // Read beat k pairs adjacent rows 2k and 2k+1
    assign rd_row1 = {rd_beat, 1'b0};
    assign rd_row2 = {rd_beat, 1'b1};

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;

    // Bank storage, fill flags and read/write pointers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            full    <= '0;
            wr_sel  <= 1'b0;
            rd_sel  <= 1'b0;
            wr_beat <= '0;
            rd_beat <= '0;
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < int'(ROWS); r++) begin
                    for (int l = 0; l < int'(LANES); l++) begin
                        mem[b][r][l] <= '0;
                    end
                end
            end
        end else begin
            if (wr_en) begin
                for (int l = 0; l < int'(LANES); l++) begin
                    mem[wr_sel][wr_row1][l] <= {r1_re[l], r1_im[l]};
                    mem[wr_sel][wr_row2][l] <= {r2_re[l], r2_im[l]};
                end
                if (wr_last) begin
                    full[wr_sel] <= 1'b1;
                    wr_sel       <= !wr_sel;
                    wr_beat      <= '0;
                end else begin
                    wr_beat <= wr_beat + beat_t'(1);
                end
            end
            // Writes and reads always target different banks, so both may retire together
            if (rd_en) begin
                if (rd_last) begin
                    full[rd_sel] <= 1'b0;
                    rd_sel       <= !rd_sel;
                    rd_beat      <= '0;
                end else begin
                    rd_beat <= rd_beat + beat_t'(1);
                end
            end
        end
    end

    // Shuffled output mux, zeroed while no frame is ready
    always_comb begin
        for (int l = 0; l < int'(LANES); l++) begin
            bus.out1_re[l] = '0;
            bus.out1_im[l] = '0;
            bus.out2_re[l] = '0;
            bus.out2_im[l] = '0;
            if (out_valid_c) begin
                bus.out1_re[l] = mem[rd_sel][rd_row1][l].re;
                bus.out1_im[l] = mem[rd_sel][rd_row1][l].im;
                bus.out2_re[l] = mem[rd_sel][rd_row2][l].re;
                bus.out2_im[l] = mem[rd_sel][rd_row2][l].im;
            end
        end
    end

endmodule
